instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
// - Inverse of the control decoder: turns mnemonic requests (op code + register/immediate fields) into 32-bit MIPS words.
// - Streams the words with addresses to the instruction-memory loader for self-test and bring-up programs.
// - Valid/ready on both sides; one-entry registered output stage.
// - FSM handles start, run, done and illegal-op stop.
// PARAMETERS
// - ADDR_W    default 10   byte-address width of InstrAddr; address wraps modulo 2^ADDR_W
// - MAX_WORDS default 256  words emitted before DONE (1..2^(ADDR_W-2))
// PORTS
// - Clk        in   1       clock; all state updates on rising edge
// - Rst        in   1       reset; synchronous and active-low (sampled on Clk, asserted when 0)
// - Start      in   1       1-cycle pulse: load BaseAddr, clear Count/IllegalOp, enter RUN
// - BaseAddr   in   ADDR_W  start byte address; bits [1:0] ignored (forced 0)
// - InValid    in   1       request valid
// - InReady    out  1       request accepted when InValid&&InReady
// - Mnemonic   in   5       op select (table below)
// - Rs,Rt,Rd   in   5 each  register fields
// - Shamt      in   5       shift amount, R-type only
// - Imm        in   16      immediate / branch offset
// - Target     in   26      J/JAL word target
// - OutValid   out  1       InstrWord/InstrAddr valid
// - OutReady   in   1       consumer accepts when OutValid&&OutReady
// - InstrWord  out  32      encoded instruction
// - InstrAddr  out  ADDR_W  byte address of InstrWord
// - Count      out  ADDR_W  words handed off since Start
// - Done       out  1       MAX_WORDS emitted
// - IllegalOp  out  1       sticky: unsupported mnemonic received
// BEHAVIOUR
// - Reset: state IDLE; InReady=0, OutValid=0, InstrWord=0, InstrAddr=0, Count=0, Done=0, IllegalOp=0.
// - FSM: IDLE -Start-> RUN; RUN -(Count reaches MAX_WORDS on output handshake)-> DONE;
//   RUN -(illegal mnemonic accepted)-> ERR; DONE/ERR -Start-> RUN. Start in RUN restarts (pending output dropped).
// - InReady = (state==RUN) && (!OutValid || OutReady) && !(last word in flight). Always 0 in IDLE/DONE/ERR.
// - Latency: accepted request appears on InstrWord with OutValid=1 next cycle; back-to-back at 1 word/cycle.
// - OutValid holds, InstrWord/InstrAddr stable until handshake; no bubble on simultaneous accept+handoff.
// - Output handshake: InstrAddr += 4 (mod 2^ADDR_W), Count += 1. First word's address = {BaseAddr[ADDR_W-1:2],2'b00}.
// - Encodings: R = {6'h00,Rs,Rt,Rd,Shamt,funct}; I = {op,Rs,Rt,Imm}; J = {op,Target}.
//   0 ADD f20 | 1 SUB f22 | 2 AND f24 | 3 OR f25 | 4 SLT f2A | 5 JR f08 (Rt,Rd,Shamt=0)
//   6 J op02 | 7 JAL op03 | 8 BEQ op04 | 9 BNE op05 | 10 BLEZ op06 (Rt=0) | 11 BGTZ op07 (Rt=0)
//   12 BLTZ op01 Rt=0 | 13 BGEZ op01 Rt=1 | 14 LUI op0F Rs=0 | 15 LW op23 | 16 SW op2B | 17 LB op20
//   18 SB op28 | 19 ADDI op08 | 20 ADDIU op09 | 21 SLTI op0A | 22 ANDI op0C | 23 ORI op0D
//   24 XORI op0E | 25 MUL op1C f02 | 26 SUPER (see CONFIGURATION) | 27-31 illegal
// - Fields forced to 0 by the table override inputs. Shamt ignored for all but codes 0-4.
// - Illegal mnemonic: no word emitted, IllegalOp=1, ->ERR; word already in output stage still drains.
// - Simultaneous Start and input handshake: Start wins, request is discarded.
// - Rst low mid-stream: all state to reset values next edge, pending word lost.
// CONFIGURATION
// - SUPER_OP_EN defined: code 26 encodes {6'h3F,Rs,Rt,Rd,11'h000} (SuperAdder op, R-format fields).
// - SUPER_OP_EN undefined: code 26 is illegal (IllegalOp, ->ERR).
// TESTING
// - Rst low 2 cycles, Start BaseAddr=0x040, ADD Rs=1 Rt=2 Rd=3 -> next cycle InstrWord=0x00221820, InstrAddr=0x040, OutValid=1.
// - ADDI Rs=0 Rt=8 Imm=0xFFFF, then J Target=0x0000010 with OutReady=1 -> 0x2008FFFF @0x040, 0x08000010 @0x044, Count=2.
// - Hold OutReady=0 with 3 queued requests -> InReady=0, InstrWord stable; release -> 3 words at 1/cycle, no loss/duplication.
// - MAX_WORDS=4, BaseAddr=0x3F8 (ADDR_W=10): addresses 0x3F8,0x3FC,0x000,0x004; Done=1, InReady=0 after 4th handshake.
// - Mnemonic=30 -> no OutValid, IllegalOp=1, ERR; Start -> IllegalOp=0, RUN. Mnemonic=26: 0xFC221800 (Rs1 Rt2 Rd3) with SUPER_OP_EN, illegal without.
// - BGEZ Rs=4 Imm=0x0003 -> 0x04810003; Rst low while OutValid=1 -> OutValid=0, Count=0 next cycle.

Source files
------------

// File: rtl/instr_encoder.sv
// Mnemonic-to-MIPS encoder that streams words with byte addresses to the instruction-memory loader.
// Optional SUPER_OP_EN macro makes code 26 encode the SuperAdder op; undefined, code 26 is illegal.
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic              InValid,
  output logic              InReady,
  input  logic [4:0]        Mnemonic,
  input  logic [4:0]        Rs,
  input  logic [4:0]        Rt,
  input  logic [4:0]        Rd,
  input  logic [4:0]        Shamt,
  input  logic [15:0]       Imm,
  input  logic [25:0]       Target,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [31:0]       InstrWord,
  output logic [ADDR_W-1:0] InstrAddr,
  output logic [ADDR_W-1:0] Count,
  output logic              Done,
  output logic              IllegalOp
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  localparam logic [ADDR_W:0] MAX_L = (ADDR_W + 1)'(MAX_WORDS);

  state_t            state_q;
  logic              out_valid_q;
  logic [31:0]       word_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              illegal_q;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              last_in_flight;
  logic              in_hs, out_hs;
  logic [ADDR_W-1:0] base_aligned;

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (Mnemonic)
      5'd0:  enc_word = {6'h00, Rs, Rt, Rd, Shamt, 6'h20};
      5'd1:  enc_word = {6'h00, Rs, Rt, Rd, Shamt, 6'h22};
      5'd2:  enc_word = {6'h00, Rs, Rt, Rd, Shamt, 6'h24};
      5'd3:  enc_word = {6'h00, Rs, Rt, Rd, Shamt, 6'h25};
      5'd4:  enc_word = {6'h00, Rs, Rt, Rd, Shamt, 6'h2A};
      5'd5:  enc_word = {6'h00, Rs, 5'd0, 5'd0, 5'd0, 6'h08};
      5'd6:  enc_word = {6'h02, Target};
      5'd7:  enc_word = {6'h03, Target};
      5'd8:  enc_word = {6'h04, Rs, Rt, Imm};
      5'd9:  enc_word = {6'h05, Rs, Rt, Imm};
      5'd10: enc_word = {6'h06, Rs, 5'd0, Imm};
      5'd11: enc_word = {6'h07, Rs, 5'd0, Imm};
      5'd12: enc_word = {6'h01, Rs, 5'd0, Imm};
      5'd13: enc_word = {6'h01, Rs, 5'd1, Imm};
      5'd14: enc_word = {6'h0F, 5'd0, Rt, Imm};
      5'd15: enc_word = {6'h23, Rs, Rt, Imm};
      5'd16: enc_word = {6'h2B, Rs, Rt, Imm};
      5'd17: enc_word = {6'h20, Rs, Rt, Imm};
      5'd18: enc_word = {6'h28, Rs, Rt, Imm};
      5'd19: enc_word = {6'h08, Rs, Rt, Imm};
      5'd20: enc_word = {6'h09, Rs, Rt, Imm};
      5'd21: enc_word = {6'h0A, Rs, Rt, Imm};
      5'd22: enc_word = {6'h0C, Rs, Rt, Imm};
      5'd23: enc_word = {6'h0D, Rs, Rt, Imm};
      5'd24: enc_word = {6'h0E, Rs, Rt, Imm};
      5'd25: enc_word = {6'h1C, Rs, Rt, Rd, 5'd0, 6'h02};
`ifdef SUPER_OP_EN
      5'd26: enc_word = {6'h3F, Rs, Rt, Rd, 11'h000};
`else
      5'd26: enc_legal = 1'b0;
`endif
      default: enc_legal = 1'b0;
    endcase
  end

  // Once the final word sits in the output stage nothing more may be accepted.
  assign last_in_flight = out_valid_q && (({1'b0, count_q} + 1'b1) == MAX_L);
  assign InReady        = (state_q == S_RUN) && (!out_valid_q || OutReady) && !last_in_flight;
  assign in_hs          = InValid && InReady;
  assign out_hs         = out_valid_q && OutReady;
  assign addr_d         = addr_q + ADDR_W'(4);
  assign count_d        = count_q + 1'b1;
  assign base_aligned   = BaseAddr & ~ADDR_W'(3);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      word_q      <= 32'h0;
      addr_q      <= '0;
      count_q     <= '0;
      illegal_q   <= 1'b0;
    end else if (Start) begin
      state_q     <= S_RUN;
      out_valid_q <= 1'b0;
      addr_q      <= base_aligned;
      count_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      if (out_hs) begin
        out_valid_q <= 1'b0;
        addr_q      <= addr_d;
        count_q     <= count_d;
        if (state_q == S_RUN && {1'b0, count_d} == MAX_L) state_q <= S_DONE;
      end
      // A new accept overrides the clear above, so the stage refills without a bubble.
      if (in_hs) begin
        if (enc_legal) begin
          out_valid_q <= 1'b1;
          word_q      <= enc_word;
        end else begin
          illegal_q <= 1'b1;
          state_q   <= S_ERR;
        end
      end
    end
  end

  assign OutValid  = out_valid_q;
  assign InstrWord = word_q;
  assign InstrAddr = addr_q;
  assign Count     = count_q;
  assign Done      = (state_q == S_DONE);
  assign IllegalOp = illegal_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table, streaming/backpressure, wrap/Done, illegal, reset.
module tb_instr_encoder;
  localparam int AW = 10;
  localparam int MW = 4;

  logic          Clk = 1'b0;
  logic          Rst, Start, InValid, OutReady;
  logic [AW-1:0] BaseAddr;
  logic [4:0]    Mnemonic, Rs, Rt, Rd, Shamt;
  logic [15:0]   Imm;
  logic [25:0]   Target;
  logic          InReady, OutValid, Done, IllegalOp;
  logic [31:0]   InstrWord;
  logic [AW-1:0] InstrAddr, Count;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  instr_encoder #(.ADDR_W(AW), .MAX_WORDS(MW)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .BaseAddr(BaseAddr),
    .InValid(InValid), .InReady(InReady), .Mnemonic(Mnemonic),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Imm(Imm), .Target(Target),
    .OutValid(OutValid), .OutReady(OutReady), .InstrWord(InstrWord),
    .InstrAddr(InstrAddr), .Count(Count), .Done(Done), .IllegalOp(IllegalOp)
  );

  typedef struct {
    logic [4:0]  mn, rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
    bit          legal;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                         input logic [25:0] tgt);
    Mnemonic = mn; Rs = rs; Rt = rt; Rd = rd; Shamt = sh; Imm = imm; Target = tgt;
  endtask

  task automatic do_start(input logic [AW-1:0] base);
    Start = 1'b1; BaseAddr = base;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp_exp[3];
    logic [AW-1:0] wrap_exp[4];
    int src, snk, last_cyc, nout;

    //          mn     rs     rt     rd     sh     imm       tgt          exp           legal
    vecs[0]  = '{5'd0,  5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 26'h0,       32'h00221820, 1'b1}; // ADD
    vecs[1]  = '{5'd1,  5'd4,  5'd5,  5'd6,  5'd7,  16'h0000, 26'h0,       32'h008531E2, 1'b1}; // SUB
    vecs[2]  = '{5'd4,  5'd8,  5'd9,  5'd10, 5'd0,  16'h0000, 26'h0,       32'h0109502A, 1'b1}; // SLT
    vecs[3]  = '{5'd5,  5'd31, 5'd5,  5'd6,  5'd7,  16'h0000, 26'h0,       32'h03E00008, 1'b1}; // JR
    vecs[4]  = '{5'd6,  5'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000010, 32'h08000010, 1'b1}; // J
    vecs[5]  = '{5'd7,  5'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF, 1'b1}; // JAL
    vecs[6]  = '{5'd8,  5'd1,  5'd2,  5'd0,  5'd0,  16'hFFFC, 26'h0,       32'h1022FFFC, 1'b1}; // BEQ
    vecs[7]  = '{5'd10, 5'd3,  5'd9,  5'd0,  5'd0,  16'h0010, 26'h0,       32'h18600010, 1'b1}; // BLEZ
    vecs[8]  = '{5'd12, 5'd2,  5'd7,  5'd0,  5'd0,  16'h0001, 26'h0,       32'h04400001, 1'b1}; // BLTZ
    vecs[9]  = '{5'd13, 5'd4,  5'd0,  5'd0,  5'd0,  16'h0003, 26'h0,       32'h04810003, 1'b1}; // BGEZ
    vecs[10] = '{5'd14, 5'd5,  5'd1,  5'd0,  5'd0,  16'h1234, 26'h0,       32'h3C011234, 1'b1}; // LUI
    vecs[11] = '{5'd15, 5'd29, 5'd8,  5'd0,  5'd0,  16'h0004, 26'h0,       32'h8FA80004, 1'b1}; // LW
    vecs[12] = '{5'd16, 5'd29, 5'd8,  5'd0,  5'd0,  16'h0004, 26'h0,       32'hAFA80004, 1'b1}; // SW
    vecs[13] = '{5'd19, 5'd0,  5'd8,  5'd0,  5'd0,  16'hFFFF, 26'h0,       32'h2008FFFF, 1'b1}; // ADDI
    vecs[14] = '{5'd23, 5'd0,  5'd2,  5'd0,  5'd0,  16'hABCD, 26'h0,       32'h3402ABCD, 1'b1}; // ORI
    vecs[15] = '{5'd25, 5'd1,  5'd2,  5'd3,  5'd5,  16'h0000, 26'h0,       32'h70221802, 1'b1}; // MUL
    vecs[16] = '{5'd30, 5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 26'h0,       32'h00000000, 1'b0}; // illegal
`ifdef SUPER_OP_EN
    vecs[17] = '{5'd26, 5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 26'h0,       32'hFC221800, 1'b1}; // SUPER
`else
    vecs[17] = '{5'd26, 5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 26'h0,       32'h00000000, 1'b0}; // SUPER off
`endif

    Rst = 1'b0; Start = 1'b0; InValid = 1'b0; OutReady = 1'b0; BaseAddr = '0;
    set_req(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    tick(); tick();
    check("rst_outvalid", {31'b0, OutValid}, 32'd0);
    check("rst_inready", {31'b0, InReady}, 32'd0);
    check("rst_word", InstrWord, 32'h0);
    check("rst_addr", {22'b0, InstrAddr}, 32'h0);
    check("rst_count", {22'b0, Count}, 32'h0);
    check("rst_done", {31'b0, Done}, 32'd0);
    check("rst_illegal", {31'b0, IllegalOp}, 32'd0);
    Rst = 1'b1;
    tick();

    // Encoding table: each vector after a fresh Start at 0x040.
    for (int i = 0; i < NV; i++) begin
      do_start(10'h040);
      set_req(vecs[i].mn, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm, vecs[i].tgt);
      InValid = 1'b1; OutReady = 1'b0;
      #1;
      check("vec_inready", {31'b0, InReady}, 32'd1);
      tick();
      InValid = 1'b0;
      if (vecs[i].legal) begin
        check("vec_outvalid", {31'b0, OutValid}, 32'd1);
        check("vec_word", InstrWord, vecs[i].exp);
        check("vec_addr", {22'b0, InstrAddr}, 32'h040);
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        check("vec_drained", {31'b0, OutValid}, 32'd0);
        check("vec_count", {22'b0, Count}, 32'd1);
      end else begin
        check("vec_ill_outvalid", {31'b0, OutValid}, 32'd0);
        check("vec_ill_flag", {31'b0, IllegalOp}, 32'd1);
        check("vec_ill_inready", {31'b0, InReady}, 32'd0);
      end
      $display("vec %0d mnemonic=%0d word=0x%08h expected=0x%08h legal=%0d",
               i, vecs[i].mn, InstrWord, vecs[i].exp, vecs[i].legal);
    end

    // Back-to-back ADDI then J with the consumer always ready.
    do_start(10'h040);
    OutReady = 1'b1;
    set_req(5'd19, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'h0); InValid = 1'b1;
    tick();
    set_req(5'd6, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010);
    #1;
    check("b2b_word0", InstrWord, 32'h2008FFFF);
    check("b2b_addr0", {22'b0, InstrAddr}, 32'h040);
    check("b2b_inready", {31'b0, InReady}, 32'd1);
    tick();
    InValid = 1'b0;
    check("b2b_word1", InstrWord, 32'h08000010);
    check("b2b_addr1", {22'b0, InstrAddr}, 32'h044);
    tick();
    OutReady = 1'b0;
    check("b2b_count", {22'b0, Count}, 32'd2);
    $display("b2b done count=%0d", Count);

    // Backpressure: consumer stalls for 4 cycles, then three words must stream at 1/cycle.
    bp_exp[0] = 32'h00222020; bp_exp[1] = 32'h00222820; bp_exp[2] = 32'h00223020;
    do_start(10'h100);
    src = 0; snk = 0; last_cyc = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      InValid = (src < 3);
      set_req(5'd0, 5'd1, 5'd2, 5'(src + 4), 5'd0, 16'h0, 26'h0);
      OutReady = (cyc >= 4);
      #1;
      if (OutValid && !OutReady) begin
        check("bp_stall_inready", {31'b0, InReady}, 32'd0);
        check("bp_stall_word", InstrWord, bp_exp[0]);
      end
      if (OutValid && OutReady) begin
        if (snk < 3) begin
          check("bp_word", InstrWord, bp_exp[snk]);
          check("bp_addr", {22'b0, InstrAddr}, 32'h100 + 32'(4 * snk));
          $display("bp out %0d word=0x%08h addr=0x%03h cycle=%0d", snk, InstrWord, InstrAddr, cyc);
        end
        snk++;
        last_cyc = cyc;
      end
      if (InValid && InReady) src++;
      tick();
    end
    InValid = 1'b0; OutReady = 1'b0;
    check("bp_nwords", 32'(snk), 32'd3);
    check("bp_last_cycle", 32'(last_cyc), 32'd6);

    // Address wrap and Done after MAX_WORDS; low base bits are ignored.
    wrap_exp[0] = 10'h3F8; wrap_exp[1] = 10'h3FC; wrap_exp[2] = 10'h000; wrap_exp[3] = 10'h004;
    do_start(10'h3FA);
    nout = 0;
    OutReady = 1'b1; InValid = 1'b1;
    set_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (cyc == 4) check("wrap_last_in_flight", {31'b0, InReady}, 32'd0);
      if (OutValid && OutReady) begin
        if (nout < 4) begin
          check("wrap_addr", {22'b0, InstrAddr}, {22'b0, wrap_exp[nout]});
          $display("wrap out %0d addr=0x%03h", nout, InstrAddr);
        end
        nout++;
      end
      tick();
    end
    InValid = 1'b0;
    check("wrap_nwords", 32'(nout), 32'd4);
    check("wrap_done", {31'b0, Done}, 32'd1);
    check("wrap_inready", {31'b0, InReady}, 32'd0);
    check("wrap_count", {22'b0, Count}, 32'd4);

    // Illegal op is sticky until Start, then RUN resumes.
    do_start(10'h040);
    set_req(5'd30, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0); InValid = 1'b1;
    tick();
    InValid = 1'b0;
    tick();
    check("ill_sticky", {31'b0, IllegalOp}, 32'd1);
    check("ill_outvalid", {31'b0, OutValid}, 32'd0);
    do_start(10'h040);
    check("ill_cleared", {31'b0, IllegalOp}, 32'd0);
    check("ill_restart_inready", {31'b0, InReady}, 32'd1);
    $display("illegal/restart illegal=%0d inready=%0d", IllegalOp, InReady);

    // Start together with an input handshake discards the request.
    set_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0); InValid = 1'b1; Start = 1'b1;
    tick();
    Start = 1'b0; InValid = 1'b0;
    check("start_wins_outvalid", {31'b0, OutValid}, 32'd0);
    check("start_wins_count", {22'b0, Count}, 32'd0);
    $display("start+request outvalid=%0d", OutValid);

    // Reset while a word is pending.
    set_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0); InValid = 1'b1;
    tick();
    OutReady = 1'b1;
    tick();
    InValid = 1'b0; OutReady = 1'b0;
    check("pre_rst_outvalid", {31'b0, OutValid}, 32'd1);
    check("pre_rst_count", {22'b0, Count}, 32'd1);
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    check("midrst_outvalid", {31'b0, OutValid}, 32'd0);
    check("midrst_count", {22'b0, Count}, 32'd0);
    check("midrst_word", InstrWord, 32'h0);
    check("midrst_inready", {31'b0, InReady}, 32'd0);
    $display("mid-stream reset outvalid=%0d count=%0d", OutValid, Count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
